// File: rtl/sar_avg_seq.sv
// sar_avg_seq -- conversion sequencer and oversampling averager for a SAR ADC.
//
// Issues one-cycle start pulses to the SAR and captures a result on each
// rising edge of end-of-conversion. After 2^LogAvg captures it presents the
// mean over a valid/ready handshake. No conversion starts while an averaged
// word is waiting to be accepted.
//
// Build option:
//   SAR_AVG_ROUND_EN  defined   -> round-half-up average
//                     undefined -> truncating average
//
// Ports:
//   clk_i     clock, rising edge
//   rst_i     asynchronous active-high reset
//   enable_i  run request
//   gap_i     idle cycles between a capture/handshake and the next start_o
//   result_i  SAR result, sampled in the cycle eoc_i rises
//   eoc_i     SAR end-of-conversion (level or pulse)
//   start_o   one-cycle start pulse to the SAR
//   data_o    averaged result (registered)
//   valid_o   data_o valid
//   ready_i   downstream accepts data_o
//   busy_o    sequencer not idle
module sar_avg_seq #(
    parameter int Width  = 6,
    parameter int LogAvg = 2
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             enable_i,
    input  logic [7:0]       gap_i,
    input  logic [Width-1:0] result_i,
    input  logic             eoc_i,
    output logic             start_o,
    output logic [Width-1:0] data_o,
    output logic             valid_o,
    input  logic             ready_i,
    output logic             busy_o
);

    localparam int AW = Width + LogAvg;
    localparam logic [LogAvg:0] CNT_FULL = (LogAvg + 1)'(2 ** LogAvg);

    typedef enum logic [2:0] {IDLE, START, WAIT_EOC, GAP, OUT} state_t;

    state_t             state_q, state_d;
    logic [AW-1:0]      acc_q, acc_d;
    logic [LogAvg:0]    cnt_q, cnt_d;
    logic [7:0]         gap_q, gap_d;
    logic [Width-1:0]   data_q, data_d;
    logic               eoc_q;

    logic               eoc_rise;
    logic [AW-1:0]      sum;
    logic [LogAvg:0]    cnt_inc;
    logic [Width-1:0]   avg;

    assign eoc_rise = eoc_i & ~eoc_q;
    assign sum      = acc_q + AW'(result_i);
    assign cnt_inc  = cnt_q + (LogAvg + 1)'(1);

`ifdef SAR_AVG_ROUND_EN
    // Half an LSB of the output added before the shift; zero when there is
    // no averaging so the result passes straight through.
    localparam int HALF_SH = (LogAvg > 0) ? LogAvg - 1 : 0;
    localparam logic [AW:0] HALF = (AW + 1)'((LogAvg > 0) ? 2 ** HALF_SH : 0);
    logic [AW:0] rnd;
    assign rnd = {1'b0, sum} + HALF;
    assign avg = rnd[LogAvg +: Width];
`else
    assign avg = sum[LogAvg +: Width];
`endif

    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        cnt_d   = cnt_q;
        gap_d   = gap_q;
        data_d  = data_q;
        case (state_q)
            IDLE: begin
                acc_d = '0;
                cnt_d = '0;
                if (enable_i) state_d = START;
            end
            START: state_d = WAIT_EOC;
            // enable_i deliberately not looked at: a started conversion completes.
            WAIT_EOC: begin
                if (eoc_rise) begin
                    acc_d = sum;
                    cnt_d = cnt_inc;
                    if (cnt_inc == CNT_FULL) begin
                        data_d  = avg;
                        state_d = OUT;
                    end else begin
                        gap_d   = gap_i;
                        state_d = GAP;
                    end
                end
            end
            GAP: begin
                if (!enable_i) begin
                    // Abort: the partial block is dropped.
                    acc_d   = '0;
                    cnt_d   = '0;
                    state_d = IDLE;
                end else if (gap_q == 8'd0) begin
                    state_d = START;
                end else begin
                    gap_d = gap_q - 8'd1;
                end
            end
            OUT: begin
                if (ready_i) begin
                    acc_d = '0;
                    cnt_d = '0;
                    if (enable_i) begin
                        gap_d   = gap_i;
                        state_d = GAP;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            acc_q   <= '0;
            cnt_q   <= '0;
            gap_q   <= '0;
            data_q  <= '0;
            eoc_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
            gap_q   <= gap_d;
            data_q  <= data_d;
            eoc_q   <= eoc_i;
        end
    end

    assign start_o = (state_q == START);
    assign valid_o = (state_q == OUT);
    assign busy_o  = (state_q != IDLE);
    assign data_o  = data_q;

endmodule

// File: tb/tb_sar_avg_seq.sv
// Directed testbench for sar_avg_seq (Width=6, LogAvg=2). The bench plays the
// SAR by hand: it waits for start_o, then raises eoc_i with a result.
module tb_sar_avg_seq;

    logic       clk, rst, enable, ready, eoc;
    logic [7:0] gap;
    logic [5:0] result;
    logic       start_o, valid_o, busy_o;
    logic [5:0] data_o;

    int n_chk  = 0;
    int n_fail = 0;

    // Cycle index = number of rising edges seen so far.
    int cyc = 0;
    int start_cnt = 0;
    int last_start_cyc = 0;
    int eoc_c = 0;

`ifdef SAR_AVG_ROUND_EN
    localparam logic [5:0] EXP_A  = 6'd12;  // 10,11,12,13
    localparam logic [5:0] EXP_BP = 6'd3;   // 1,2,3,5
    localparam logic [5:0] EXP_HS = 6'd32;  // 30,31,32,33
`else
    localparam logic [5:0] EXP_A  = 6'd11;
    localparam logic [5:0] EXP_BP = 6'd2;
    localparam logic [5:0] EXP_HS = 6'd31;
`endif

    sar_avg_seq #(.Width(6), .LogAvg(2)) dut (
        .clk_i(clk), .rst_i(rst), .enable_i(enable), .gap_i(gap),
        .result_i(result), .eoc_i(eoc), .start_o(start_o), .data_o(data_o),
        .valid_o(valid_o), .ready_i(ready), .busy_o(busy_o)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (start_o) begin
            start_cnt      <= start_cnt + 1;
            last_start_cyc <= cyc;
        end
    end

    task automatic wait_start(input int target);
        int n = 0;
        while (start_cnt < target && n < 300) begin
            @(negedge clk);
            n++;
        end
        if (start_cnt < target) begin
            n_chk++; n_fail++;
            $display("FAIL start_timeout: starts=%0d required=%0d", start_cnt, target);
        end
    endtask

    task automatic wait_valid();
        int n = 0;
        while (!valid_o && n < 300) begin
            @(negedge clk);
            n++;
        end
        if (!valid_o) begin
            n_chk++; n_fail++;
            $display("FAIL valid_timeout: valid_o=%0b required=1", valid_o);
        end
    endtask

    // Called at a negedge while the DUT waits for eoc.
    task automatic conv(input logic [5:0] res, input int hold);
        eoc    = 1'b1;
        result = res;
        eoc_c  = cyc;
        repeat (hold) @(negedge clk);
        eoc = 1'b0;
        @(negedge clk);
    endtask

    task automatic run_block(input int s0, input logic [5:0] a, b, c, d,
                             input int hold, input int g, input bit chk_gap);
        logic [5:0] r [4];
        r[0] = a; r[1] = b; r[2] = c; r[3] = d;
        for (int i = 0; i < 4; i++) begin
            wait_start(s0 + i + 1);
            if (chk_gap && i > 0) begin
                n_chk++;
                if (last_start_cyc - eoc_c !== 2 + g) begin
                    n_fail++;
                    $display("FAIL gap_timing[%0d]: got=%0d required=%0d", i,
                             last_start_cyc - eoc_c, 2 + g);
                end
            end
            conv(r[i], hold);
        end
        wait_valid();
    endtask

    task automatic handshake(input logic en);
        ready  = 1'b1;
        enable = en;
        @(negedge clk);
        ready = 1'b0;
        n_chk++;
        if (valid_o !== 1'b0) begin
            n_fail++;
            $display("FAIL valid_fall: got=%0b required=0", valid_o);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; enable = 1'b0; ready = 1'b0; eoc = 1'b0; gap = 8'd0; result = 6'd0;
        repeat (3) @(negedge clk);
        n_chk += 4;
        if (start_o !== 1'b0) begin n_fail++; $display("FAIL reset_start: got=%0b required=0", start_o); end
        if (valid_o !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got=%0b required=0", valid_o); end
        if (data_o !== 6'd0)  begin n_fail++; $display("FAIL reset_data: got=%0d required=0", data_o); end
        if (busy_o !== 1'b0)  begin n_fail++; $display("FAIL reset_busy: got=%0b required=0", busy_o); end
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_average();
        int s0 = start_cnt;
        gap = 8'd0;
        enable = 1'b1;
        run_block(s0, 6'd10, 6'd11, 6'd12, 6'd13, 1, 0, 1'b1);
        n_chk += 2;
        if (data_o !== EXP_A) begin n_fail++; $display("FAIL avg_data: got=%0d required=%0d", data_o, EXP_A); end
        if (start_cnt - s0 !== 4) begin n_fail++; $display("FAIL avg_starts: got=%0d required=4", start_cnt - s0); end
        handshake(1'b0);
        n_chk++;
        if (busy_o !== 1'b0) begin n_fail++; $display("FAIL avg_idle: busy=%0b required=0", busy_o); end
    endtask

    task automatic test_max();
        enable = 1'b1;
        run_block(start_cnt, 6'd63, 6'd63, 6'd63, 6'd63, 1, 0, 1'b0);
        n_chk++;
        if (data_o !== 6'd63) begin n_fail++; $display("FAIL max_data: got=%0d required=63", data_o); end
        handshake(1'b0);
    endtask

    // eoc held for 3 cycles must count once: 4,8,12,16 averages to 10.
    task automatic test_gap();
        int s0 = start_cnt;
        gap = 8'd5;
        enable = 1'b1;
        run_block(s0, 6'd4, 6'd8, 6'd12, 6'd16, 3, 5, 1'b1);
        n_chk += 2;
        if (data_o !== 6'd10) begin n_fail++; $display("FAIL gap_data: got=%0d required=10", data_o); end
        if (start_cnt - s0 !== 4) begin n_fail++; $display("FAIL gap_starts: got=%0d required=4", start_cnt - s0); end
        handshake(1'b0);
    endtask

    task automatic test_back_to_back();
        int sc, hc;
        gap = 8'd0;
        enable = 1'b1;
        run_block(start_cnt, 6'd1, 6'd2, 6'd3, 6'd5, 1, 0, 1'b0);
        sc = start_cnt;
        for (int i = 0; i < 20; i++) begin
            n_chk += 2;
            if (valid_o !== 1'b1) begin n_fail++; $display("FAIL bp_valid[%0d]: got=%0b required=1", i, valid_o); end
            if (data_o !== EXP_BP) begin n_fail++; $display("FAIL bp_data[%0d]: got=%0d required=%0d", i, data_o, EXP_BP); end
            @(negedge clk);
        end
        n_chk++;
        if (start_cnt !== sc) begin n_fail++; $display("FAIL bp_no_start: got=%0d required=%0d", start_cnt, sc); end
        gap = 8'd2;
        hc = cyc;
        handshake(1'b1);
        wait_start(sc + 1);
        n_chk++;
        if (last_start_cyc - hc !== 4) begin
            n_fail++;
            $display("FAIL hs_gap: got=%0d required=4", last_start_cyc - hc);
        end
        run_block(sc, 6'd30, 6'd31, 6'd32, 6'd33, 1, 2, 1'b1);
        n_chk++;
        if (data_o !== EXP_HS) begin n_fail++; $display("FAIL hs_data: got=%0d required=%0d", data_o, EXP_HS); end
        handshake(1'b0);
    endtask

    task automatic test_abort();
        int s0 = start_cnt;
        int sc;
        gap = 8'd0;
        enable = 1'b1;
        wait_start(s0 + 1);
        conv(6'd50, 1);
        wait_start(s0 + 2);
        enable = 1'b0;              // dropped during WAIT_EOC of sample 2
        conv(6'd50, 1);
        repeat (2) @(negedge clk);
        n_chk += 2;
        if (busy_o !== 1'b0)  begin n_fail++; $display("FAIL abort_busy: got=%0b required=0", busy_o); end
        if (valid_o !== 1'b0) begin n_fail++; $display("FAIL abort_valid: got=%0b required=0", valid_o); end
        sc = start_cnt;
        repeat (10) @(negedge clk);
        n_chk++;
        if (start_cnt !== sc) begin n_fail++; $display("FAIL abort_no_start: got=%0d required=%0d", start_cnt, sc); end
        enable = 1'b1;
        run_block(sc, 6'd20, 6'd20, 6'd20, 6'd20, 1, 0, 1'b0);
        n_chk++;
        if (data_o !== 6'd20) begin n_fail++; $display("FAIL abort_residue: got=%0d required=20", data_o); end
        handshake(1'b0);
    endtask

    task automatic test_reset_mid();
        int s0 = start_cnt;
        gap = 8'd10;
        enable = 1'b1;
        wait_start(s0 + 1);
        conv(6'd9, 1);
        n_chk++;
        if (busy_o !== 1'b1) begin n_fail++; $display("FAIL gap_busy: got=%0b required=1", busy_o); end
        rst = 1'b1;
        #1;
        n_chk += 2;
        if (busy_o !== 1'b0)  begin n_fail++; $display("FAIL rst_gap_busy: got=%0b required=0", busy_o); end
        if (start_o !== 1'b0) begin n_fail++; $display("FAIL rst_gap_start: got=%0b required=0", start_o); end
        @(negedge clk);
        rst = 1'b0;
        gap = 8'd0;
        run_block(start_cnt, 6'd7, 6'd7, 6'd7, 6'd7, 1, 0, 1'b0);
        n_chk++;
        if (data_o !== 6'd7) begin n_fail++; $display("FAIL pre_rst_data: got=%0d required=7", data_o); end
        rst = 1'b1;
        #1;
        n_chk += 3;
        if (valid_o !== 1'b0) begin n_fail++; $display("FAIL rst_out_valid: got=%0b required=0", valid_o); end
        if (data_o !== 6'd0)  begin n_fail++; $display("FAIL rst_out_data: got=%0d required=0", data_o); end
        if (busy_o !== 1'b0)  begin n_fail++; $display("FAIL rst_out_busy: got=%0b required=0", busy_o); end
        @(negedge clk);
        rst = 1'b0;                 // enable still high
        n_chk++;
        if (start_o !== 1'b0) begin n_fail++; $display("FAIL rel_start0: got=%0b required=0", start_o); end
        @(negedge clk);
        n_chk++;
        if (start_o !== 1'b1) begin n_fail++; $display("FAIL rel_start1: got=%0b required=1", start_o); end
        enable = 1'b0;
        conv(6'd1, 1);
    endtask

    initial begin
        test_reset();
        test_average();
        test_max();
        test_gap();
        test_back_to_back();
        test_abort();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
